// File: rtl/pmem_responder_if.sv
// Line-granular physical-memory bus between a requester (L2 cache) and pmem_responder.
interface pmem_responder_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/pmem_responder.sv
// Fixed-latency 256-bit line memory responder for the L2 pmem port.
// Optional read/write completion counters are built when PMEM_STATS_EN is defined.
module pmem_responder #(
  parameter int unsigned lines    = 64,
  parameter int unsigned log_line = 6,
  parameter int unsigned latency  = 4
) (
  input  logic               clk,
  input  logic               reset,
  pmem_responder_if.slave    bus,
  output logic               protocol_err,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [3:0] LatM1 = 4'(latency - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic [log_line-1:0]   idx_q, idx_d;
  logic [255:0]          wdata_q, wdata_d;
  logic [255:0]          rdata_q, rdata_d;
  logic                  perr_q, perr_d;
  logic [255:0]          mem_q [lines];
  logic                  mem_we;
  logic [log_line-1:0]   req_idx;
  logic                  unused_addr;

  assign req_idx     = bus.pmem_address[log_line+4:5];
  assign unused_addr = ^{bus.pmem_address[15:log_line+5], bus.pmem_address[4:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    perr_d  = perr_q;
    case (state_q)
      StIdle: begin
        if (bus.pmem_read || bus.pmem_write) begin
          // A read+write conflict is served as a write.
          op_wr_d = bus.pmem_write;
          idx_d   = req_idx;
          wdata_d = bus.pmem_wdata;
          cnt_d   = LatM1;
          if (bus.pmem_read && bus.pmem_write) perr_d = 1'b1;
          if (latency == 1) begin
            state_d = StResp;
            if (!bus.pmem_write) rdata_d = mem_q[req_idx];
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
          if (!op_wr_q) rdata_d = mem_q[idx_q];
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  // Write commits on the edge leaving RESP; a reset in that cycle aborts it.
  assign mem_we = (state_q == StResp) && op_wr_q && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign bus.pmem_resp  = (state_q == StResp);
  assign bus.pmem_rdata = rdata_q;
  assign protocol_err   = perr_q;

`ifdef PMEM_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == StResp) begin
      if (op_wr_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = 16'h0000;
  assign wr_count = 16'h0000;
`endif

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Synthesizable physical-memory responder for the 256-bit line interface that the L2 cache drives (pmem_read/pmem_write/pmem_address/pmem_wdata -> pmem_resp/pmem_rdata).
- Holds a line-granular backing array and answers each request with a fixed, parameterized latency.
- Sits below the L2 cache in the mp3 system for FPGA bring-up, and serves as the reference responder in cache/arbiter benches.

Parameters:
- lines, 64, number of 256-bit lines in the backing array (power of 2)
- log_line, 6, log2(lines); index = pmem_address[log_line+4:5]
- latency, 4, cycles from request acceptance to pmem_resp (legal range 1..15)

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- pmem_read  in  1  read request, held by requester until pmem_resp
- pmem_write  in  1  write request, held by requester until pmem_resp
- pmem_address  in  16  byte address; bits [4:0] ignored
- pmem_wdata  in  256  write line (lc3b_block)
- pmem_resp  out  1  one-cycle completion pulse
- pmem_rdata  out  256  read line (lc3b_block), valid in the resp cycle and held until the next read resp
- protocol_err  out  1  sticky; set when read and write are sampled high together
- rd_count  out  16  completed reads (see Optional Feature)
- wr_count  out  16  completed writes (see Optional Feature)

Behaviour:
- Reset (sync, active-high): state=IDLE; pmem_resp=0, pmem_rdata=0, protocol_err=0, rd_count=0, wr_count=0; latency counter=0. Array contents are not cleared.
- FSM states:
  - IDLE: on a posedge with pmem_read|pmem_write high, latch op, index and wdata, load cnt=latency-1, then go BUSY (or RESP when latency==1).
  - BUSY: decrement cnt each cycle; when cnt==1, go RESP.
  - RESP: pmem_resp=1 for exactly this cycle, then go IDLE.
- Latency: resp is asserted exactly latency cycles after the accepting edge (latency=4 means request sampled at edge N, resp high during cycle N+4).
- Read: array[index] is loaded into pmem_rdata at the edge entering RESP, so data is stable throughout the resp cycle. pmem_rdata is unchanged by writes.
- Write: latched wdata is committed to array[index] at the edge leaving RESP.
- Request latch: op, index and wdata come only from the accepting edge; input changes during BUSY/RESP are ignored.
- Dropped request: if the requester deasserts mid-transaction, the transaction still completes and resp still pulses.
- Back-to-back: a request high in the cycle after RESP is a new transaction, accepted from IDLE. A requester that holds read through resp is therefore served twice; the protocol requires deassertion on resp.
- Read and write both high at acceptance: treat as write and set protocol_err. It clears only on reset.
- Address aliasing: bits above log_line+4 are ignored (wrap-around).
- Reset mid-transaction: abort with no array commit and no resp; IDLE on the next cycle.
- Counters: increment in the resp cycle, saturating at 16'hFFFF.

Optional Feature:
- Macro: PMEM_STATS_EN.
- Defined: rd_count/wr_count increment and saturate as above.
- Undefined: both outputs tied to 16'h0000 and the counter logic is not built.
- All other behaviour is identical in both builds.

Test Plan:
- Write then read, latency=4: write 0x0040 with wdata={8{32'hDEADBEEF}}, then read 0x0040 -> resp exactly 4 cycles after each accept; rdata={8{32'hDEADBEEF}}; with PMEM_STATS_EN, wr_count=1 and rd_count=1.
- Aliasing and low bits, lines=64: write 0x0020 with pattern A, then read 0x0820 and 0x003F -> both return A.
- Dropped request: assert read 0x0100 for 1 cycle only -> resp still pulses at cycle +4; a held write issued afterwards is accepted the cycle after that resp.
- Conflict: read and write both high to 0x0200 with wdata=256'h1 -> write performed, protocol_err=1 and sticky; a subsequent read of 0x0200 returns 256'h1.
- Reset mid-op: write 0x0300 with 256'hF, assert reset at cycle +2 -> no resp; a later read of 0x0300 returns the prior contents, not 256'hF; all outputs 0 after reset.
- latency=1 and back-to-back: three consecutive reads, each deasserted on resp -> resp one cycle after each accept, one idle cycle between transactions, no missed or duplicated responses.
